// File: rtl/conv33_pkg.sv
// Shared encodings and constants for the conv33 window scheduler.
package conv33_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int KERNEL_TAPS = 9;
  localparam int WIDX_W      = 4;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(KERNEL_TAPS - 1);

  function automatic logic is_busy(input state_e s);
    return s != ST_IDLE;
  endfunction

  // Results are only accepted while windows can be outstanding.
  function automatic logic takes_results(input state_e s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/conv33_credit_cnt.sv
// Up/down count of windows accepted by the engine but not yet returned.
module conv33_credit_cnt #(
  parameter int CNT_W   = 4,
  parameter int MAX_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic empty,
  output logic full_nxt,
  output logic empty_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign empty     = (cnt_q == '0);
  assign full_nxt  = (cnt_d == CNT_MAX);
  assign empty_nxt = (cnt_d == '0);

endmodule

// File: rtl/conv33_sched.sv
// Sequencer for one conv33 engine: weight load, raster window issue with
// credit limiting, result drain and a single done pulse per map.
module conv33_sched
  import conv33_pkg::*;
#(
  parameter int DIM_W        = 8,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_out_w,
  input  logic [DIM_W-1:0]  cfg_out_h,
  output logic              busy,
  output logic              done,
  output logic              wt_valid,
  output logic [WIDX_W-1:0] wt_idx,
  input  logic              wt_ready,
  output logic              win_valid,
  output logic [DIM_W-1:0]  win_row,
  output logic [DIM_W-1:0]  win_col,
  input  logic              win_ready,
  input  logic              res_valid,
  output logic              res_ready
);

  localparam int PROD_W = 2 * DIM_W;
  localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
  localparam logic [PROD_W-1:0] PROD_ONE = PROD_W'(1);
  localparam logic [WIDX_W-1:0] WIDX_ONE = WIDX_W'(1);

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   w_q, w_d, h_q, h_d;
  logic [DIM_W-1:0]   row_q, row_d, col_q, col_d;
  logic [PROD_W-1:0]  total_q, total_d, res_cnt_q, res_cnt_d;
  logic [WIDX_W-1:0]  wt_idx_q, wt_idx_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               wt_valid_q, wt_valid_d, win_valid_q, win_valid_d;
  logic               res_ready_q, res_ready_d;

  logic wt_fire, win_fire, res_fire;
  logic cnt_empty, cnt_full_nxt, cnt_empty_nxt;

  assign wt_fire  = wt_valid_q & wt_ready;
  assign win_fire = win_valid_q & win_ready;
  assign res_fire = res_valid & res_ready_q;

  conv33_credit_cnt #(
    .CNT_W   (CNT_W),
    .MAX_CNT (MAX_INFLIGHT)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .inc       (win_fire),
    .dec       (res_fire),
    .empty     (cnt_empty),
    .full_nxt  (cnt_full_nxt),
    .empty_nxt (cnt_empty_nxt)
  );

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    total_d   = total_q;
    row_d     = row_q;
    col_d     = col_q;
    wt_idx_d  = wt_idx_q;
    res_cnt_d = res_fire ? (res_cnt_q + PROD_ONE) : res_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d       = cfg_out_w;
          h_d       = cfg_out_h;
          total_d   = PROD_W'(cfg_out_w) * PROD_W'(cfg_out_h);
          row_d     = '0;
          col_d     = '0;
          wt_idx_d  = '0;
          res_cnt_d = '0;
          state_d   = ((cfg_out_w == '0) || (cfg_out_h == '0)) ? ST_DONE : ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (wt_fire) begin
          if (wt_idx_q == WIDX_LAST) begin
            wt_idx_d = '0;
            state_d  = ST_RUN;
          end else begin
            wt_idx_d = wt_idx_q + WIDX_ONE;
          end
        end
      end
      ST_RUN: begin
        // Coordinates only move on a fire, so they hold while the engine stalls.
        if (win_fire) begin
          if (col_q == (w_q - DIM_ONE)) begin
            col_d = '0;
            if (row_q == (h_q - DIM_ONE)) begin
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + DIM_ONE;
            end
          end else begin
            col_d = col_q + DIM_ONE;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_empty && (res_cnt_q == total_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from next state so they register alongside it.
    busy_d      = is_busy(state_d);
    done_d      = (state_d == ST_DONE);
    wt_valid_d  = (state_d == ST_LOAD_W);
    win_valid_d = (state_d == ST_RUN) && !cnt_full_nxt;
    res_ready_d = takes_results(state_d) && !cnt_empty_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      total_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      wt_idx_q    <= '0;
      res_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wt_valid_q  <= 1'b0;
      win_valid_q <= 1'b0;
      res_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      total_q     <= total_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wt_idx_q    <= wt_idx_d;
      res_cnt_q   <= res_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wt_valid_q  <= wt_valid_d;
      win_valid_q <= win_valid_d;
      res_ready_q <= res_ready_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wt_valid  = wt_valid_q;
  assign wt_idx    = wt_idx_q;
  assign win_valid = win_valid_q;
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign res_ready = res_ready_q;

endmodule

// File: tb/tb_conv33_sched.sv
// Directed + randomized bench for conv33_sched with a raster-order reference model.
module tb_conv33_sched;

  localparam int DIM_W        = 8;
  localparam int MAX_INFLIGHT = 4;
  localparam int CNT_W        = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DIM_W-1:0] cfg_out_w, cfg_out_h;
  logic             busy, done, wt_valid, wt_ready;
  logic [3:0]       wt_idx;
  logic             win_valid, win_ready, res_valid, res_ready;
  logic [DIM_W-1:0] win_row, win_col;

  always #5 clk = ~clk;

  conv33_sched #(
    .DIM_W        (DIM_W),
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_out_w (cfg_out_w),
    .cfg_out_h (cfg_out_h),
    .busy      (busy),
    .done      (done),
    .wt_valid  (wt_valid),
    .wt_idx    (wt_idx),
    .wt_ready  (wt_ready),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_ready (win_ready),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake log, sampled mid-cycle: what is valid&ready now fires on the next edge.
  logic [15:0] win_log[$];
  int          win_cyc[$];
  logic [3:0]  wt_log[$];
  int          wt_cyc[$];
  int          win_fires, res_fires, done_cnt, stall_viol, max_pending;
  int          wt_valid_cycles, win_valid_cycles;
  logic        stalled;
  logic [15:0] stall_coord;
  bit          res_en, wt_rand, win_rand, res_rand;

  always @(negedge clk) begin
    if (stalled && win_valid && ({win_row, win_col} != stall_coord)) stall_viol++;
    stalled     = win_valid && !win_ready;
    stall_coord = {win_row, win_col};
    if (wt_valid)  wt_valid_cycles++;
    if (win_valid) win_valid_cycles++;
    if (wt_valid && wt_ready) begin
      wt_log.push_back(wt_idx);
      wt_cyc.push_back(cyc);
    end
    if (win_valid && win_ready) begin
      win_log.push_back({win_row, win_col});
      win_cyc.push_back(cyc);
      win_fires++;
    end
    if (res_valid && res_ready) res_fires++;
    if (done) done_cnt++;
    if (win_fires - res_fires > max_pending) max_pending = win_fires - res_fires;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    win_log.delete();
    win_cyc.delete();
    wt_log.delete();
    wt_cyc.delete();
    win_fires        = 0;
    res_fires        = 0;
    done_cnt         = 0;
    stall_viol       = 0;
    max_pending      = 0;
    wt_valid_cycles  = 0;
    win_valid_cycles = 0;
    stalled          = 1'b0;
  endtask

  // One clock; peers respond 1 ns after the edge. Results return one cycle
  // after their window is accepted unless held or randomly delayed.
  task automatic tick();
    @(posedge clk);
    #1;
    wt_ready  = wt_rand  ? 1'($urandom_range(0, 1)) : 1'b1;
    win_ready = win_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    res_valid = res_en && (win_fires > res_fires) &&
                (res_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  task automatic do_start(input int w, input int h, output int s);
    cfg_out_w = DIM_W'(w);
    cfg_out_h = DIM_W'(h);
    start     = 1'b1;
    tick();
    start = 1'b0;
    s     = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_timeout"}, 32'(n < budget), 32'd1);
  endtask

  // Reference: every (row,col) of a WxH map exactly once in raster order.
  task automatic check_windows(input int w, input int h, input string tag);
    logic [15:0] exp_q[$];
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back({8'(r), 8'(c)});
    check({tag, "_win_count"}, 32'(win_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < win_log.size()) check({tag, "_win_order"}, 32'(win_log[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic check_weights(input string tag);
    check({tag, "_wt_count"}, 32'(wt_log.size()), 32'd9);
    for (int k = 0; k < wt_log.size(); k++) check({tag, "_wt_idx"}, 32'(wt_log[k]), 32'(k));
  endtask

  initial begin
    int s, n;
    rst       = 1'b1;
    start     = 1'b0;
    cfg_out_w = '0;
    cfg_out_h = '0;
    wt_ready  = 1'b0;
    win_ready = 1'b0;
    res_valid = 1'b0;
    res_en    = 1'b1;
    wt_rand   = 1'b0;
    win_rand  = 1'b0;
    res_rand  = 1'b0;
    clear_log();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({busy, done, wt_valid, win_valid, res_ready, wt_idx, win_row, win_col}), 32'd0);
    rst = 1'b0;
    tick();
    clear_log();

    // 1: 3x2 map, always-ready peers, 1-cycle result return
    do_start(3, 2, s);
    check("t1_busy_cycle1", 32'(busy), 32'd1);
    check("t1_wt_first", 32'({wt_valid, wt_idx}), 32'h10);
    wait_done(100, "t1");
    check_weights("t1");
    for (int k = 0; k < wt_cyc.size(); k++) check("t1_wt_cycle", 32'(wt_cyc[k] - s + 1), 32'(k + 1));
    if (win_cyc.size() > 0) check("t1_first_win_cycle", 32'(win_cyc[0] - s + 1), 32'd10);
    check_windows(3, 2, "t1");
    tick();
    check("t1_after_done", 32'({busy, done}), 32'd0);
    check("t1_done_pulses", 32'(done_cnt), 32'd1);
    check("t1_results", 32'(res_fires), 32'd6);

    // 2: credit limit with results withheld
    clear_log();
    res_en = 1'b0;
    do_start(4, 4, s);
    repeat (30) tick();
    check("t2_fires_held", 32'(win_fires), 32'(MAX_INFLIGHT));
    check("t2_win_valid_low", 32'(win_valid), 32'd0);
    check("t2_res_ready_high", 32'(res_ready), 32'd1);
    res_en = 1'b1;
    wait_done(300, "t2");
    tick();
    check_windows(4, 4, "t2");
    check("t2_results", 32'(res_fires), 32'd16);
    check("t2_max_pending", 32'(max_pending <= MAX_INFLIGHT), 32'd1);

    // 3: random back-pressure on every peer over a 5x4 map
    clear_log();
    wt_rand  = 1'b1;
    win_rand = 1'b1;
    res_rand = 1'b1;
    do_start(5, 4, s);
    wait_done(3000, "t3");
    tick();
    wt_rand  = 1'b0;
    win_rand = 1'b0;
    res_rand = 1'b0;
    check_weights("t3");
    check_windows(5, 4, "t3");
    check("t3_stall_hold", 32'(stall_viol), 32'd0);
    check("t3_results", 32'(res_fires), 32'd20);
    check("t3_max_pending", 32'(max_pending <= MAX_INFLIGHT), 32'd1);
    check("t3_done_pulses", 32'(done_cnt), 32'd1);

    // 4: zero-sized maps skip straight to done
    clear_log();
    do_start(0, 5, s);
    check("t4_busy_done", 32'({busy, done}), 32'h3);
    tick();
    check("t4_after_done", 32'({busy, done}), 32'd0);
    do_start(6, 0, s);
    check("t4h_busy_done", 32'({busy, done}), 32'h3);
    repeat (3) tick();
    check("t4_no_wt", 32'(wt_valid_cycles), 32'd0);
    check("t4_no_win", 32'(win_valid_cycles), 32'd0);
    check("t4_done_pulses", 32'(done_cnt), 32'd2);

    // 5: reset mid-RUN at window (1,1), then a fresh map
    clear_log();
    do_start(4, 3, s);
    n = 0;
    while (!(win_valid && win_row == 8'd1 && win_col == 8'd1) && n < 100) begin
      tick();
      n++;
    end
    check("t5_reached_1_1", 32'(n < 100), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_reset_outputs", 32'({busy, done, wt_valid, win_valid, res_ready, wt_idx, win_row, win_col}), 32'd0);
    repeat (2) tick();
    res_valid = 1'b0;
    clear_log();
    rst = 1'b0;
    tick();
    check("t5_idle_busy", 32'(busy), 32'd0);
    do_start(2, 2, s);
    check("t5_reload_idx0", 32'({wt_valid, wt_idx}), 32'h10);
    wait_done(100, "t5");
    tick();
    check_weights("t5");
    check_windows(2, 2, "t5");
    check("t5_results", 32'(res_fires), 32'd4);

    // 6: start while busy and in the DONE cycle is ignored
    clear_log();
    do_start(3, 3, s);
    n = 0;
    while (win_fires < 2 && n < 50) begin
      tick();
      n++;
    end
    check("t6_reached_run", 32'(n < 50), 32'd1);
    cfg_out_w = 8'd7;
    cfg_out_h = 8'd7;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("t6_busy_run", 32'(busy), 32'd1);
    wait_done(200, "t6");
    cfg_out_w = 8'd2;
    cfg_out_h = 8'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("t6_start_in_done", 32'(busy), 32'd0);
    repeat (3) tick();
    check("t6_still_idle", 32'(busy), 32'd0);
    check_windows(3, 3, "t6");
    check("t6_results", 32'(res_fires), 32'd9);
    check("t6_done_pulses", 32'(done_cnt), 32'd1);
    clear_log();
    do_start(2, 2, s);
    wait_done(100, "t6b");
    tick();
    check_windows(2, 2, "t6b");
    check("t6b_results", 32'(res_fires), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
